// File: rtl/micro_pkg.sv
// Shared definitions for the microprogram sequencer: FSM encoding and
// control-word field positions.
package micro_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StExec  = 3'd2,
    StWait  = 3'd3,
    StHalt  = 3'd4
  } state_e;

  localparam int unsigned NEXT_LSB = 0;
  localparam int unsigned NEXT_MSB = 7;
  localparam int unsigned ZEN_BIT  = 8;
  localparam int unsigned EN_BIT   = 9;
  localparam int unsigned ZLD_BIT  = 10;
  localparam int unsigned MEM_BIT  = 11;
  localparam int unsigned HALT_BIT = 12;
  localparam int unsigned CTRL_LSB = 13;

  localparam logic [7:0] DEFAULT_RESET_ADDR = 8'h00;

endpackage

// File: rtl/micro_sequencer_if.sv
// Signal bundle between the sequencer and the rest of the control unit
// (control store, address decoder, memory and ALU).
interface micro_sequencer_if #(
  parameter int unsigned CW_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH = 8
);

  logic                   START;
  logic [ADDR_WIDTH-1:0]  FinAdd;
  logic [CW_WIDTH-1:0]    RomData;
  logic                   MEMRDY;
  logic                   ALUZ;
  logic [ADDR_WIDTH-1:0]  RomAdd;
  logic [ADDR_WIDTH-1:0]  MicroAdd;
  logic                   ZEN;
  logic                   EN;
  logic                   Z;
  logic [CW_WIDTH-14:0]   CTRL;
  logic                   MEMREQ;
  logic                   STEP;
  logic                   HALTED;

  // Sequencer side.
  modport slave (
    input  START, FinAdd, RomData, MEMRDY, ALUZ,
    output RomAdd, MicroAdd, ZEN, EN, Z, CTRL, MEMREQ, STEP, HALTED
  );

  // Control-unit side.
  modport master (
    output START, FinAdd, RomData, MEMRDY, ALUZ,
    input  RomAdd, MicroAdd, ZEN, EN, Z, CTRL, MEMREQ, STEP, HALTED
  );

endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: MPC, control-word register, Z flag and memory-wait
// handshake. The external address decoder closes the loop via FinAdd.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int unsigned          CW_WIDTH   = 32,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(DEFAULT_RESET_ADDR)
) (
  input logic               CLK,
  input logic               RSTN,
  micro_sequencer_if.slave  bus
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] mpc_q;
  logic [CW_WIDTH-1:0]   cw_q;
  logic                  z_q;

  logic mem_pending;
  logic retire;
  logic active;

  assign mem_pending = cw_q[MEM_BIT] & ~bus.MEMRDY;
  assign active      = (state_q == StExec) || (state_q == StWait);

  always_comb begin
    retire = 1'b0;
    case (state_q)
      StExec:  retire = ~cw_q[HALT_BIT] & ~mem_pending;
      StWait:  retire = bus.MEMRDY;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      mpc_q   <= RESET_ADDR;
      cw_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle:  if (bus.START) state_q <= StFetch;
        StFetch: begin
          cw_q    <= bus.RomData;
          state_q <= StExec;
        end
        StExec: begin
          if (cw_q[HALT_BIT])   state_q <= StHalt;
          else if (mem_pending) state_q <= StWait;
          else                  state_q <= StFetch;
        end
        StWait:  if (bus.MEMRDY) state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase

      // Z only changes on a retiring edge, so the decoder sees the pre-instruction value.
      if (retire) begin
        mpc_q <= bus.FinAdd;
        if (cw_q[ZLD_BIT]) z_q <= bus.ALUZ;
      end
    end
  end

  // STEP and MEMREQ follow MEMRDY within the cycle so a same-cycle MEMRDY skips WAIT.
  assign bus.RomAdd   = mpc_q;
  assign bus.MicroAdd = ADDR_WIDTH'(cw_q[NEXT_MSB:NEXT_LSB]);
  assign bus.ZEN      = cw_q[ZEN_BIT];
  assign bus.EN       = cw_q[EN_BIT];
  assign bus.Z        = z_q;
  assign bus.CTRL     = active ? cw_q[CW_WIDTH-1:CTRL_LSB] : '0;
  assign bus.MEMREQ   = (state_q == StWait) ||
                        ((state_q == StExec) && !cw_q[HALT_BIT] && mem_pending);
  assign bus.STEP     = retire;
  assign bus.HALTED   = (state_q == StHalt);

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a combinational ROM and a small
// address-decoder model (ZEN && Z inverts the NEXT MSB).
module tb_micro_sequencer;

  logic clk;
  logic rstn;
  int   checks;
  int   passed;

  logic [31:0] rom [256];

  micro_sequencer_if #(.CW_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  micro_sequencer #(
    .CW_WIDTH  (32),
    .ADDR_WIDTH(8),
    .RESET_ADDR(8'h00)
  ) dut (
    .CLK (clk),
    .RSTN(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.RomData = rom[bus.RomAdd];

  always_comb begin
    bus.FinAdd = bus.MicroAdd;
    if (!bus.EN && bus.ZEN && bus.Z) bus.FinAdd = {~bus.MicroAdd[7], bus.MicroAdd[6:0]};
  end

  function automatic logic [31:0] mk(input logic [18:0] ctrl, input logic halt,
                                     input logic mem, input logic zld, input logic en,
                                     input logic zen, input logic [7:0] nxt);
    return {ctrl, halt, mem, zld, en, zen, nxt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_romadd"}, 32'(bus.RomAdd), 32'h00);
    chk({tag, "_microadd"}, 32'(bus.MicroAdd), 32'h00);
    chk({tag, "_zen"}, 32'(bus.ZEN), 32'h0);
    chk({tag, "_en"}, 32'(bus.EN), 32'h0);
    chk({tag, "_z"}, 32'(bus.Z), 32'h0);
    chk({tag, "_ctrl"}, 32'(bus.CTRL), 32'h0);
    chk({tag, "_memreq"}, 32'(bus.MEMREQ), 32'h0);
    chk({tag, "_step"}, 32'(bus.STEP), 32'h0);
    chk({tag, "_halted"}, 32'(bus.HALTED), 32'h0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[8'h00] = mk(19'h00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05);
    rom[8'h05] = mk(19'h01234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h06);
    rom[8'h06] = mk(19'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    rom[8'h90] = mk(19'h05A5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
    rom[8'h20] = mk(19'h00777, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30);
    rom[8'h30] = mk(19'h7FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
    rom[8'h10] = mk(19'h00ABC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);

    bus.START  = 1'b0;
    bus.MEMRDY = 1'b0;
    bus.ALUZ   = 1'b0;
    rstn       = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk_reset("reset");
    step();
    step();
    rstn = 1'b1;

    // Idle with START low
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("idle_step", 32'(bus.STEP), 32'h0);
      chk("idle_romadd", 32'(bus.RomAdd), 32'h00);
      chk("idle_ctrl", 32'(bus.CTRL), 32'h0);
    end

    // Sequential fetch 00 -> 05
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    #1;
    chk("fetch0_romadd", 32'(bus.RomAdd), 32'h00);
    chk("fetch0_step", 32'(bus.STEP), 32'h0);
    chk("fetch0_memreq", 32'(bus.MEMREQ), 32'h0);
    step();
    #1;
    chk("exec0_microadd", 32'(bus.MicroAdd), 32'h05);
    chk("exec0_step", 32'(bus.STEP), 32'h1);
    chk("exec0_ctrl", 32'(bus.CTRL), 32'h1);
    chk("exec0_zen", 32'(bus.ZEN), 32'h0);
    chk("exec0_en", 32'(bus.EN), 32'h0);
    step();
    #1;
    chk("fetch5_romadd", 32'(bus.RomAdd), 32'h05);
    chk("fetch5_step", 32'(bus.STEP), 32'h0);

    // ZLD with ALUZ=1
    step();
    bus.ALUZ = 1'b1;
    #1;
    chk("exec5_z_old", 32'(bus.Z), 32'h0);
    chk("exec5_ctrl", 32'(bus.CTRL), 32'h01234);
    chk("exec5_step", 32'(bus.STEP), 32'h1);
    step();
    bus.ALUZ = 1'b0;
    #1;
    chk("fetch6_z_new", 32'(bus.Z), 32'h1);
    chk("fetch6_romadd", 32'(bus.RomAdd), 32'h06);
    step();
    #1;
    chk("exec6_microadd", 32'(bus.MicroAdd), 32'h10);
    chk("exec6_zen", 32'(bus.ZEN), 32'h1);
    chk("exec6_step", 32'(bus.STEP), 32'h1);
    step();
    #1;
    chk("branch_taken_romadd", 32'(bus.RomAdd), 32'h90);

    // Memory wait: MEMRDY three cycles after EXEC
    step();
    #1;
    chk("exec90_memreq", 32'(bus.MEMREQ), 32'h1);
    chk("exec90_step", 32'(bus.STEP), 32'h0);
    chk("exec90_ctrl", 32'(bus.CTRL), 32'h05A5A);
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      chk("wait_memreq", 32'(bus.MEMREQ), 32'h1);
      chk("wait_step", 32'(bus.STEP), 32'h0);
      chk("wait_ctrl", 32'(bus.CTRL), 32'h05A5A);
      chk("wait_romadd", 32'(bus.RomAdd), 32'h90);
    end
    step();
    bus.MEMRDY = 1'b1;
    #1;
    chk("wait3_memreq", 32'(bus.MEMREQ), 32'h1);
    chk("wait3_step", 32'(bus.STEP), 32'h1);
    chk("wait3_ctrl", 32'(bus.CTRL), 32'h05A5A);

    // MEMRDY already high: no WAIT cycle
    step();
    #1;
    chk("fetch20_romadd", 32'(bus.RomAdd), 32'h20);
    chk("fetch20_step", 32'(bus.STEP), 32'h0);
    chk("fetch20_memreq", 32'(bus.MEMREQ), 32'h0);
    step();
    #1;
    chk("exec20_step", 32'(bus.STEP), 32'h1);
    chk("exec20_memreq", 32'(bus.MEMREQ), 32'h0);
    chk("exec20_ctrl", 32'(bus.CTRL), 32'h00777);
    step();
    bus.MEMRDY = 1'b0;
    #1;
    chk("fetch30_romadd", 32'(bus.RomAdd), 32'h30);
    chk("fetch30_step", 32'(bus.STEP), 32'h0);

    // HALT with ZLD, ALUZ=0 must not clear Z
    step();
    #1;
    chk("exec30_step", 32'(bus.STEP), 32'h0);
    chk("exec30_memreq", 32'(bus.MEMREQ), 32'h0);
    chk("exec30_halted", 32'(bus.HALTED), 32'h0);
    chk("exec30_ctrl", 32'(bus.CTRL), 32'h7FFFF);
    step();
    #1;
    chk("halt_halted", 32'(bus.HALTED), 32'h1);
    chk("halt_z", 32'(bus.Z), 32'h1);
    chk("halt_romadd", 32'(bus.RomAdd), 32'h30);
    chk("halt_ctrl", 32'(bus.CTRL), 32'h0);
    chk("halt_memreq", 32'(bus.MEMREQ), 32'h0);
    chk("halt_step", 32'(bus.STEP), 32'h0);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    step();
    #1;
    chk("halt_start_halted", 32'(bus.HALTED), 32'h1);
    chk("halt_start_romadd", 32'(bus.RomAdd), 32'h30);
    chk("halt_start_step", 32'(bus.STEP), 32'h0);

    rstn = 1'b0;
    #1;
    chk_reset("halt_reset");
    step();
    rstn = 1'b1;

    // Second run: Z stays 0, branch not taken, then reset mid-WAIT
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    step();
    step();
    step();
    step();
    #1;
    chk("run2_z", 32'(bus.Z), 32'h0);
    chk("run2_romadd6", 32'(bus.RomAdd), 32'h06);
    step();
    #1;
    chk("run2_exec6_zen", 32'(bus.ZEN), 32'h1);
    step();
    #1;
    chk("branch_not_taken_romadd", 32'(bus.RomAdd), 32'h10);
    step();
    #1;
    chk("exec10_memreq", 32'(bus.MEMREQ), 32'h1);
    chk("exec10_ctrl", 32'(bus.CTRL), 32'h00ABC);
    step();
    #1;
    chk("wait10_memreq", 32'(bus.MEMREQ), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midwait_reset_memreq", 32'(bus.MEMREQ), 32'h0);
    chk("midwait_reset_romadd", 32'(bus.RomAdd), 32'h00);
    chk("midwait_reset_ctrl", 32'(bus.CTRL), 32'h0);
    chk("midwait_reset_step", 32'(bus.STEP), 32'h0);
    bus.MEMRDY = 1'b1;
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      chk("post_reset_step", 32'(bus.STEP), 32'h0);
      chk("post_reset_memreq", 32'(bus.MEMREQ), 32'h0);
      chk("post_reset_romadd", 32'(bus.RomAdd), 32'h00);
      chk("post_reset_halted", 32'(bus.HALTED), 32'h0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the processor control unit. Holds the microprogram counter (MPC), addresses the synchronous control-store ROM, registers the fetched control word and splits it into the next-address, ZEN and EN fields that feed the address decoder, plus the datapath control bus. It takes the decoder's FinAdd back as the next MPC value. It also owns the Z flag register and the memory-wait handshake, and it sits directly upstream of, and in a loop with, the address decoder.

## Interface
Parameters:
- CW_WIDTH, 32: control word width; must be ≥ 14.
- ADDR_WIDTH, 8: microaddress width.
- RESET_ADDR, 8'h00: MPC value after reset.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- START  in  1  level; leaves IDLE when sampled high.
- FinAdd  in  ADDR_WIDTH  next microaddress from the address decoder.
- RomData  in  CW_WIDTH  control-store read data, valid one cycle after RomAdd.
- MEMRDY  in  1  memory completion strobe.
- ALUZ  in  1  ALU zero result.
- RomAdd  out  ADDR_WIDTH  control-store address (= MPC).
- MicroAdd  out  ADDR_WIDTH  CW[7:0], next-address field.
- ZEN  out  1  CW[8], conditional-branch enable.
- EN  out  1  CW[9], dispatch-on-opcode enable.
- Z  out  1  registered zero flag.
- CTRL  out  CW_WIDTH-13  CW[CW_WIDTH-1:13], datapath controls.
- MEMREQ  out  1  memory request.
- STEP  out  1  one-cycle pulse when a microinstruction retires.
- HALTED  out  1  high while in HALT.

## Operation
- Control word fields: [7:0] NEXT, [8] ZEN, [9] EN, [10] ZLD, [11] MEM, [12] HALT, [CW_WIDTH-1:13] CTRL.
- States are IDLE, FETCH, EXEC, WAIT and HALT.
- **IDLE:** CTRL=0, MEMREQ=0. Moves to FETCH when START=1.
- **FETCH:** RomAdd=MPC. At the clock edge, CWREG <= RomData. Always moves to EXEC.
- **EXEC:** CTRL = CWREG control bits. MicroAdd, ZEN and EN are driven from CWREG in every state.
  - HALT=1 takes priority over everything else: go to HALT. MPC and Z are not updated and STEP is not pulsed.
  - MEM=1 with MEMRDY=0: MEMREQ=1; go to WAIT.
  - Otherwise the instruction retires: MPC <= FinAdd, STEP=1, go to FETCH. If ZLD=1, Z <= ALUZ on the same edge.
- **WAIT:** CTRL and MEMREQ are held. When MEMRDY=1, the instruction retires exactly as in EXEC.
- **HALT:** CTRL=0, MEMREQ=0, HALTED=1. The only exit is RSTN.
- The Z value seen by the decoder during an instruction is the value latched before that instruction. A ZLD update becomes visible only from the next instruction.
- MPC wraps naturally modulo 2^ADDR_WIDTH. There is no overflow detection.
- START is ignored outside IDLE.

## Timing
- Reset (asynchronous, immediate) forces:
  - state=IDLE, MPC=RomAdd=RESET_ADDR;
  - CWREG=0, so MicroAdd=0, ZEN=0, EN=0 and CTRL=0;
  - Z=0, MEMREQ=0, STEP=0, HALTED=0.
- Reset mid-WAIT drops MEMREQ in the same cycle.
- Each non-memory microinstruction takes 2 cycles (FETCH + EXEC).
- A memory microinstruction takes 2 + k cycles, where k is the number of WAIT cycles until MEMRDY.
- A MEMRDY that arrives in the same cycle as EXEC completes without a WAIT cycle.
- MEMRDY outside EXEC/WAIT, or in an instruction with MEM=0, is ignored.
- FinAdd is sampled only on the retiring edge. The combinational path CWREG → decoder → FinAdd must settle within one cycle.
- STEP is high during the retiring cycle (EXEC or the final WAIT cycle). It is never high for two consecutive cycles.

## Structure
- The shared package `micro_pkg` holds:
  - the state encoding (3-bit enum);
  - control word field index constants: NEXT_LSB/MSB, ZEN_BIT, EN_BIT, ZLD_BIT, MEM_BIT, HALT_BIT, CTRL_LSB;
  - the RESET_ADDR default.
- No sub-module. The address decoder remains a separate instance at the control-unit top level, wired as MicroAdd/ZEN/EN/Z out and FinAdd in.

## Test plan
- **Reset and start:** reset, START=0 for 5 cycles → RomAdd=00, CTRL=0, STEP never asserted. Raise START → FETCH at 00, EXEC on the next cycle.
- **Sequential fetch:** ROM[00] NEXT=05, ZEN=EN=0; decoder model returns 05 → STEP pulse, RomAdd=05 two cycles after START.
- **Zero branch:**
  - ROM[05]: ZLD=1; ALUZ=1 → Z=1 from the following instruction onward.
  - ROM[06]: NEXT=10, ZEN=1 → FinAdd=90 (MSB inverted); MPC=90.
  - ROM[06] with Z=0 → MPC=10.
- **Memory wait:** MEM=1, MEMRDY asserted 3 cycles after EXEC → MEMREQ high for 4 cycles, CTRL stable throughout, STEP in the MEMRDY cycle, instruction total 5 cycles. Also run with MEMRDY already high in EXEC → 2 cycles, no WAIT.
- **Halt:** instruction with HALT=1 and ZLD=1 → HALTED=1, Z unchanged, RomAdd frozen, START pulses ignored. RSTN low → all outputs return to their reset values.
- **Async reset mid-WAIT:** drop RSTN between clock edges → MEMREQ=0 and MPC=00 before the next edge. MEMRDY after reset has no effect.
